// File: rtl/fifo_batch_ctrl.sv
// Batch sequencer for one FIFO: fills BATCH words from upstream, then drains
// BATCH words downstream through a 2-entry skid buffer hiding the read latency.
module fifo_batch_ctrl #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BATCH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic                  up_valid,
  output logic                  up_ready,
  output logic [DATA_WIDTH-1:0] dn_data,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic                  fifo_wren,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  fifo_rden,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_full,
  input  logic                  fifo_empty
);

  localparam int unsigned CNT_W = (BATCH > 1) ? $clog2(BATCH + 1) : 1;
  localparam logic [CNT_W-1:0] BATCH_C = CNT_W'(BATCH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BATCH - 1);

  // Reject illegal batch sizes at elaboration.
  if (BATCH == 0 || BATCH > DEPTH) begin : g_batch_range
    $error("fifo_batch_ctrl: BATCH must be in 1..DEPTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      wr_cnt;
  logic [CNT_W-1:0]      rd_cnt;
  logic [CNT_W-1:0]      out_cnt;
  logic                  inflight;
  logic                  tail_vld;
  logic [DATA_WIDTH-1:0] tail_data;
  logic                  pop;
  logic                  push;
  logic                  finish;
  logic                  fill_entry;
  logic [2:0]            occ_sum;

  assign fifo_wdata = up_data;
  assign pop        = dn_valid && dn_ready;
  assign push       = inflight;
  assign fill_entry = (state == IDLE) && start;
  // Buffer occupancy plus the read already in flight.
  assign occ_sum    = 3'(dn_valid) + 3'(tail_vld) + 3'(inflight);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and combinational handshake outputs.
  always_comb begin
    state_nxt = state;
    up_ready  = 1'b0;
    fifo_wren = 1'b0;
    fifo_rden = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        up_ready  = !fifo_full && (wr_cnt < BATCH_C);
        fifo_wren = up_valid && up_ready;
        if (fifo_wren && (wr_cnt == LAST_C)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        fifo_rden = !fifo_empty && (rd_cnt < BATCH_C) &&
                    (occ_sum < (3'd2 + 3'(pop)));
        finish    = pop && (out_cnt == LAST_C);
        if (finish) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered status flags and read-latency tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      inflight <= 1'b0;
    end else begin
      busy     <= (state_nxt != IDLE);
      done     <= finish;
      inflight <= fifo_rden;
    end
  end

  // Batch counters, cleared as FILL is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      out_cnt <= '0;
    end else if (fill_entry) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (fifo_wren) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
      if (fifo_rden) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
      if ((state == DRAIN) && pop) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end
    end
  end

  // Two-entry output buffer; head is dn_data/dn_valid, order preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid  <= 1'b0;
      dn_data   <= '0;
      tail_vld  <= 1'b0;
      tail_data <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (!dn_valid) begin
            dn_valid <= 1'b1;
            dn_data  <= fifo_rdata;
          end else begin
            tail_vld  <= 1'b1;
            tail_data <= fifo_rdata;
          end
        end
        2'b01: begin
          dn_valid <= tail_vld;
          tail_vld <= 1'b0;
          if (tail_vld) begin
            dn_data <= tail_data;
          end
        end
        2'b11: begin
          if (tail_vld) begin
            dn_data   <= tail_data;
            tail_data <= fifo_rdata;
          end else begin
            dn_data <= fifo_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_batch_ctrl.md
Name: fifo_batch_ctrl

Overview:
Sequencer that owns one FIFO_v2 instance: on a start pulse it fills the FIFO with BATCH words from an upstream valid/ready source, then drains exactly BATCH words to a downstream valid/ready sink.
- Hides the FIFO's 1-cycle read latency behind a 2-entry output buffer, so downstream sees a plain valid/ready stream.
- Sits between the input loader and the MAC/consumer stage of the minilab datapath; one controller per FIFO.

Parameters:
DEPTH, 8, depth of the attached FIFO (words).
DATA_WIDTH, 8, word width.
BATCH, 8, words per fill/drain cycle; legal range 1..DEPTH.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset; the same net drives the FIFO's aclr via inversion.
start  input  1  one-cycle request to begin a batch; honoured only in IDLE.
busy  output  1  high in FILL or DRAIN.
done  output  1  one-cycle pulse when the batch completes.
up_data  input  DATA_WIDTH  upstream word.
up_valid  input  1  upstream word valid.
up_ready  output  1  controller accepts up_data this cycle.
dn_data  output  DATA_WIDTH  downstream word (head of output buffer).
dn_valid  output  1  dn_data valid.
dn_ready  input  1  downstream accepts dn_data.
fifo_wren  output  1  to FIFO wren.
fifo_wdata  output  DATA_WIDTH  to FIFO i_data.
fifo_rden  output  1  to FIFO rden.
fifo_rdata  input  DATA_WIDTH  from FIFO o_data, valid the cycle after fifo_rden.
fifo_full  input  1  from FIFO full.
fifo_empty  input  1  from FIFO empty.

Behaviour:
- Reset (async, rst_n low): state=IDLE; all counters 0; output buffer empty; busy=0, done=0, up_ready=0, dn_valid=0, fifo_wren=0, fifo_rden=0, dn_data=0.
- Counters: wr_cnt, rd_cnt (reads issued), out_cnt (words delivered), each $clog2(BATCH+1) bits, cleared on entry to FILL.
- States: IDLE, FILL, DRAIN.
- IDLE: start=1 -> FILL next cycle. start in FILL/DRAIN is ignored, with no queuing.
- FILL:
  - up_ready = !fifo_full && (wr_cnt < BATCH), combinational.
  - fifo_wren = up_valid && up_ready; fifo_wdata = up_data (combinational pass-through); wr_cnt increments on each write.
  - fifo_full stalls without loss.
  - Cycle of the BATCH-th write -> DRAIN on the next edge.
- DRAIN:
  - up_ready=0.
  - inflight = fifo_rden registered 1 cycle; pop = dn_valid && dn_ready.
  - fifo_rden = !fifo_empty && (rd_cnt < BATCH) && (occ + inflight - pop < 2), where occ is the output-buffer occupancy (0..2).
  - The cycle after fifo_rden, fifo_rdata is pushed into the output buffer.
  - dn_data/dn_valid come from the buffer head. Push and pop in the same cycle are allowed; order is preserved.
  - Sustained throughput is 1 word/cycle with dn_ready held high. First dn_valid appears 2 cycles after DRAIN entry.
  - Backpressure: dn_data must hold stable while dn_valid && !dn_ready. The buffer never overflows.
  - On the handshake that makes out_cnt == BATCH -> IDLE next edge. done=1 for exactly that following cycle; busy=0 in the same cycle.
- Boundary conditions:
  - BATCH=DEPTH: fifo_full rises after the last write. No extra write attempted.
  - BATCH=1: single write, single read, done pulse.
  - fifo_empty unexpectedly high in DRAIN (external disturbance): reads stall and the controller waits; no error output.
  - start coincident with done cycle: done is in IDLE, so start is accepted -> FILL next cycle.
  - rst_n low mid-FILL/DRAIN: immediate return to reset values; FIFO cleared by its own aclr.

Test Plan:
- Reset, start, up_valid held high with data 0x10..0x17, dn_ready=1 -> 8 writes in 8 consecutive cycles, then dn_data 0x10..0x17 on 8 consecutive cycles, done pulses once, busy low afterwards.
- up_valid toggling 1010..., data 0xA0..0xA7 -> wr_cnt reaches 8 after 16 cycles, no duplicate or lost word; drain order matches.
- DRAIN with dn_ready pattern 1,0,0,1,1,0,1... -> dn_data stable during stalls, 8 words in order, fifo_rden never issued when occ+inflight would exceed 2.
- BATCH=1 build, data 0x5A -> one write, dn_data=0x5A, done one cycle after handshake.
- start pulsed during FILL and DRAIN -> ignored, exactly one done per batch; start on the done cycle -> new FILL begins next cycle.
- rst_n asserted after 3 writes -> all outputs 0 asynchronously, FIFO empty; a new start then completes a full 8-word batch correctly.
